uart_tx_shift: RTL

UART transmit serializer: the transmitter counterpart to the receive shift path in the UART peripheral. Accepts one byte per valid/ready handshake from the transmit holding register or FIFO, and frames it per line-control settings. The frame is start bit, 5–8 data bits LSB first, optional parity, and 1/1.5/2 stop bits. It is driven onto `serial_out` at 13x or 16x oversampling of the baud clock `bclk_in`.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_tx_shift_if.sv | 16 +
 rtl/uart_parity_gen.sv | 26 ++
 rtl/uart_tx_shift.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the transmit and receive shift paths:
//   - uart_state_e               : serializer state encoding
//   - UART_OSM13/16_CYCLES       : oversampling cycles per bit
//   - UART_STOP15_OSM13/16_CYCLES: cycle counts for a 1.5 stop bit period
//   - uart_wls_last_bit()        : word-length select -> index of last data bit
//   - uart_wls_mask()            : word-length select -> mask of active data bits
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [4:0] UART_OSM13_CYCLES        = 5'd13;
    localparam logic [4:0] UART_OSM16_CYCLES        = 5'd16;
    localparam logic [4:0] UART_STOP15_OSM13_CYCLES = 5'd20;
    localparam logic [4:0] UART_STOP15_OSM16_CYCLES = 5'd24;

    // 5..8 data bits -> last bit index 4..7
    function automatic logic [2:0] uart_wls_last_bit(input logic [1:0] wls);
        return {1'b1, wls};
    endfunction

    function automatic logic [7:0] uart_wls_mask(input logic [1:0] wls);
        logic [7:0] m;
        case (wls)
            2'd0:    m = 8'h1F;
            2'd1:    m = 8'h3F;
            2'd2:    m = 8'h7F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_tx_shift_if.sv
// -----------------------------------------------------------------------------
// uart_tx_shift_if
// Byte handshake between the transmit holding register / FIFO and the
// serializer. Transfer happens on a clock edge where valid && ready.
//   tx_data_in   : byte to send (bits above the word length are ignored)
//   tx_valid_in  : byte available
//   tx_ready_out : serializer can accept
// -----------------------------------------------------------------------------
interface uart_tx_shift_if;
    logic [7:0] tx_data_in;
    logic       tx_valid_in;
    logic       tx_ready_out;

    modport master (output tx_data_in, output tx_valid_in, input tx_ready_out);
    modport slave  (input tx_data_in, input tx_valid_in, output tx_ready_out);
endinterface

// File: rtl/uart_parity_gen.sv
// -----------------------------------------------------------------------------
// uart_parity_gen
// Combinational parity bit generator, shared by transmit (generation) and
// receive (checking).
//   data_in    : data byte, only the active word-length bits are used
//   wls_in     : word length select, 0..3 -> 5..8 bits
//   eps_in     : 1 = even parity, 0 = odd parity
//   sp_in      : stick parity, bit is forced to !eps_in
//   parity_out : parity bit
// -----------------------------------------------------------------------------
module uart_parity_gen
    import uart_pkg::*;
(
    input  logic [7:0] data_in,
    input  logic [1:0] wls_in,
    input  logic       eps_in,
    input  logic       sp_in,
    output logic       parity_out
);

    logic w_xor;

    assign w_xor      = ^(data_in & uart_wls_mask(wls_in));
    assign parity_out = sp_in ? ~eps_in : (eps_in ? w_xor : ~w_xor);

endmodule

// File: rtl/uart_tx_shift.sv
// -----------------------------------------------------------------------------
// uart_tx_shift
// UART transmit serializer. Takes one byte per handshake and sends start bit,
// 5..8 data bits LSB first, optional parity and 1 / 1.5 / 2 stop bits at 13x
// or 16x oversampling of bclk_in.
//
// Optional feature: define UART_TX_BREAK_EN to add break_in, which forces
// serial_out low (registered) while the state machine keeps running.
//
// Ports
//   bclk_in      : oversampling baud clock
//   rstn_in      : synchronous reset, active low
//   enable_in    : transmitter enable, low aborts a frame
//   osm_sel_in   : 1 = 13 cycles per bit, 0 = 16 cycles per bit
//   wls_in       : word length 0..3 -> 5..8 bits
//   stb_in       : stop bits (1, or 1.5 when 5-bit words / 2 otherwise)
//   pen_in       : parity enable
//   eps_in       : even parity select
//   sp_in        : stick parity
//   break_in     : line break (UART_TX_BREAK_EN only)
//   tx_if        : byte handshake (slave side)
//   serial_out   : serial line, idle high
//   busy_out     : frame in progress
//   done_out     : one-cycle pulse during the last stop cycle
//
// state     | meaning
// ST_IDLE   | line idle high, ready for a byte
// ST_START  | start bit, one bit period low
// ST_DATA   | data bits LSB first, shift at each bit boundary
// ST_PARITY | parity bit, skipped when parity disabled
// ST_STOP   | stop period high, last cycle may accept the next byte
// -----------------------------------------------------------------------------
module uart_tx_shift
    import uart_pkg::*;
(
    input  logic       bclk_in,
    input  logic       rstn_in,
    input  logic       enable_in,
    input  logic       osm_sel_in,
    input  logic [1:0] wls_in,
    input  logic       stb_in,
    input  logic       pen_in,
    input  logic       eps_in,
    input  logic       sp_in,
`ifdef UART_TX_BREAK_EN
    input  logic       break_in,
`endif
    uart_tx_shift_if.slave tx_if,
    output logic       serial_out,
    output logic       busy_out,
    output logic       done_out
);

    uart_state_e r_state, w_state_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [2:0]  r_last_bit, w_last_bit_nxt;
    logic        r_pen, w_pen_nxt;
    logic        r_par, w_par_nxt;
    logic [4:0]  r_plast, w_plast_nxt;
    logic [4:0]  r_stop_last, w_stop_last_nxt;
    logic        r_serial, w_serial_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;

    logic       w_par_acc;
    logic [4:0] w_p_acc;
    logic [4:0] w_stop_last_acc;
    logic       w_bit_end;
    logic       w_stop_end;
    logic       w_ready;
    logic       w_accept;
    logic       w_break;

`ifdef UART_TX_BREAK_EN
    assign w_break = break_in;
`else
    assign w_break = 1'b0;
`endif

    uart_parity_gen u_parity (
        .data_in    (tx_if.tx_data_in),
        .wls_in     (wls_in),
        .eps_in     (eps_in),
        .sp_in      (sp_in),
        .parity_out (w_par_acc)
    );

    // Stop length is captured at accept as a last-cycle index; 2 stop bits at
    // P=16 is 32 cycles, and (2P - 1) wraps correctly to 31 in 5 bits.
    assign w_p_acc = osm_sel_in ? UART_OSM13_CYCLES : UART_OSM16_CYCLES;

    always_comb begin
        w_stop_last_acc = w_p_acc - 5'd1;
        if (stb_in) begin
            if (wls_in == 2'd0)
                w_stop_last_acc = (osm_sel_in ? UART_STOP15_OSM13_CYCLES
                                              : UART_STOP15_OSM16_CYCLES) - 5'd1;
            else
                w_stop_last_acc = (w_p_acc << 1) - 5'd1;
        end
    end

    assign w_bit_end  = (r_cnt == r_plast);
    assign w_stop_end = (r_state == ST_STOP) && (r_cnt == r_stop_last);
    assign w_ready    = rstn_in && enable_in && ((r_state == ST_IDLE) || w_stop_end);
    assign w_accept   = w_ready && tx_if.tx_valid_in;

    assign tx_if.tx_ready_out = w_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + 5'd1;
        w_bit_nxt       = r_bit;
        w_shift_nxt     = r_shift;
        w_last_bit_nxt  = r_last_bit;
        w_pen_nxt       = r_pen;
        w_par_nxt       = r_par;
        w_plast_nxt     = r_plast;
        w_stop_last_nxt = r_stop_last;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = 5'd0;
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = 5'd0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = 5'd0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == r_last_bit)
                        w_state_nxt = r_pen ? ST_PARITY : ST_STOP;
                    else
                        w_bit_nxt = r_bit + 3'd1;
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = 5'd0;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_stop_end) begin
                    w_cnt_nxt   = 5'd0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = 5'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Accept can only happen in IDLE or on the last stop cycle, so it
        // overrides whatever the case above decided.
        if (w_accept) begin
            w_state_nxt     = ST_START;
            w_cnt_nxt       = 5'd0;
            w_shift_nxt     = tx_if.tx_data_in & uart_wls_mask(wls_in);
            w_last_bit_nxt  = uart_wls_last_bit(wls_in);
            w_pen_nxt       = pen_in;
            w_par_nxt       = w_par_acc;
            w_plast_nxt     = w_p_acc - 5'd1;
            w_stop_last_nxt = w_stop_last_acc;
        end

        if (!enable_in) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 5'd0;
        end

        // Outputs are registered from the next state so the line has no glitches.
        case (w_state_nxt)
            ST_START:  w_serial_nxt = 1'b0;
            ST_DATA:   w_serial_nxt = w_shift_nxt[0];
            ST_PARITY: w_serial_nxt = w_par_nxt;
            default:   w_serial_nxt = 1'b1;
        endcase
        if (w_break)
            w_serial_nxt = 1'b0;

        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (w_state_nxt == ST_STOP) && (w_cnt_nxt == w_stop_last_nxt);
    end

    always_ff @(posedge bclk_in) begin
        if (!rstn_in) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 5'd0;
            r_bit       <= 3'd0;
            r_shift     <= 8'd0;
            r_last_bit  <= 3'd0;
            r_pen       <= 1'b0;
            r_par       <= 1'b0;
            r_plast     <= 5'd0;
            r_stop_last <= 5'd0;
            r_serial    <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit       <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_last_bit  <= w_last_bit_nxt;
            r_pen       <= w_pen_nxt;
            r_par       <= w_par_nxt;
            r_plast     <= w_plast_nxt;
            r_stop_last <= w_stop_last_nxt;
            r_serial    <= w_serial_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign serial_out = r_serial;
    assign busy_out   = r_busy;
    assign done_out   = r_done;

endmodule
